n101_pllcfg_icb_seq: RTL



---
 rtl/n101_pllcfg_icb_seq.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/n101_pllcfg_icb_seq.sv
// -----------------------------------------------------------------------------
// n101_pllcfg_icb_seq
//
// ICB initiator that brings up the HCLK generator on request. After an
// accepted start it walks the hclkgen register slave through:
//   W0  HFXOSC enable            (0x004 <= 0x4000_0000)
//   wait XOSC_WAIT cycles
//   W1  PLL dividers, bypass=1   (0x008 <= 0x0004_0000 | P)
//   wait LOCK_WAIT cycles
//   W2  output divider           (0x00C <= outdivby1<<8 | outdiv)
//   W3  leave bypass             (0x008 <= P)
//   R4  read back PLLCFG         (0x008), err if rdata != P
// where P = OD<<13 | M<<5 | N taken from the copies latched at start.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start                one-cycle request, accepted only when idle
//   cfg_N/M/OD/outdiv/outdivby1  PLL settings, latched on accepted start
//   busy                 high from the cycle after start until the DONE cycle
//   done, err            sticky status, cleared by the next accepted start
//   o_icb_cmd_*          ICB command channel (initiator side)
//   o_icb_rsp_*          ICB response channel, rsp_ready tied high
//   dbg_state_o          current FSM state, for observation only
//
// Handshake semantics: a command transfers in the cycle where cmd_valid and
// cmd_ready are both 1. cmd_valid/addr/read/wdata are registered, raised on
// state entry and held unchanged until that transfer; cmd_valid drops the
// cycle after it. Exactly one transaction is outstanding from the transfer
// cycle until the first cycle (the transfer cycle included) with
// rsp_valid=1; that response is consumed and the FSM advances. rsp_valid
// while nothing is outstanding is ignored.
// -----------------------------------------------------------------------------
module n101_pllcfg_icb_seq #(
  parameter int CNT_W     = 16,
  parameter int XOSC_WAIT = 1024,
  parameter int LOCK_WAIT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  cfg_N,
  input  logic [7:0]  cfg_M,
  input  logic [1:0]  cfg_OD,
  input  logic [5:0]  cfg_outdiv,
  input  logic        cfg_outdivby1,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        o_icb_cmd_valid,
  input  logic        o_icb_cmd_ready,
  output logic [11:0] o_icb_cmd_addr,
  output logic        o_icb_cmd_read,
  output logic [31:0] o_icb_cmd_wdata,
  input  logic        o_icb_rsp_valid,
  output logic        o_icb_rsp_ready,
  input  logic [31:0] o_icb_rsp_rdata,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_W0    = 4'd1,
    S_XWAIT = 4'd2,
    S_W1    = 4'd3,
    S_LWAIT = 4'd4,
    S_W2    = 4'd5,
    S_W3    = 4'd6,
    S_R4    = 4'd7,
    S_DONE  = 4'd8
  } state_e;

  // Counters run from WAIT-1 down to 0, so a state spends exactly WAIT cycles.
  localparam logic [CNT_W-1:0] XW_LOAD = CNT_W'(XOSC_WAIT - 1);
  localparam logic [CNT_W-1:0] LW_LOAD = CNT_W'(LOCK_WAIT - 1);

  localparam logic [11:0] A_HFXOSC = 12'h004;
  localparam logic [11:0] A_PLLCFG = 12'h008;
  localparam logic [11:0] A_OUTDIV = 12'h00C;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [11:0]       cmd_addr_q, cmd_addr_d;
  logic              cmd_read_q, cmd_read_d;
  logic [31:0]       cmd_wdata_q, cmd_wdata_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        n_q, n_d;
  logic [7:0]        m_q, m_d;
  logic [1:0]        od_q, od_d;
  logic [5:0]        outdiv_q, outdiv_d;
  logic              by1_q, by1_d;

  logic              cmd_hs;
  logic              rsp_take;
  logic [31:0]       pllcfg_w;

  // PLLCFG value without bypass; bits 31..15 are always zero.
  assign pllcfg_w = {17'd0, od_q, m_q, n_q};

  assign cmd_hs = cmd_valid_q & o_icb_cmd_ready;
  // A response may arrive in the handshake cycle itself (pend_q not yet set).
  assign rsp_take = o_icb_rsp_valid & (pend_q | cmd_hs);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_read_d  = cmd_read_q;
    cmd_wdata_d = cmd_wdata_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    m_d         = m_q;
    od_d        = od_q;
    outdiv_d    = outdiv_q;
    by1_d       = by1_q;

    if (cmd_hs) begin
      cmd_valid_d = 1'b0;
      pend_d      = 1'b1;
    end
    if (rsp_take) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d         = cfg_N;
          m_d         = cfg_M;
          od_d        = cfg_OD;
          outdiv_d    = cfg_outdiv;
          by1_d       = cfg_outdivby1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_W0;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = A_HFXOSC;
          cmd_read_d  = 1'b0;
          cmd_wdata_d = 32'h4000_0000;
        end
      end
      S_W0: begin
        if (rsp_take) begin
          state_d = S_XWAIT;
          cnt_d   = XW_LOAD;
        end
      end
      S_XWAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_W1;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = A_PLLCFG;
          cmd_read_d  = 1'b0;
          cmd_wdata_d = 32'h0004_0000 | pllcfg_w;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_W1: begin
        if (rsp_take) begin
          state_d = S_LWAIT;
          cnt_d   = LW_LOAD;
        end
      end
      S_LWAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_W2;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = A_OUTDIV;
          cmd_read_d  = 1'b0;
          cmd_wdata_d = {23'd0, by1_q, 2'b00, outdiv_q};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_W2: begin
        if (rsp_take) begin
          state_d     = S_W3;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = A_PLLCFG;
          cmd_read_d  = 1'b0;
          cmd_wdata_d = pllcfg_w;
        end
      end
      S_W3: begin
        if (rsp_take) begin
          state_d     = S_R4;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = A_PLLCFG;
          cmd_read_d  = 1'b1;
          cmd_wdata_d = 32'd0;
        end
      end
      S_R4: begin
        if (rsp_take) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = (o_icb_rsp_rdata != pllcfg_w);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        cmd_valid_d = 1'b0;
        pend_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= 12'd0;
      cmd_read_q  <= 1'b0;
      cmd_wdata_q <= 32'd0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      n_q         <= 5'd0;
      m_q         <= 8'd0;
      od_q        <= 2'd0;
      outdiv_q    <= 6'd0;
      by1_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_read_q  <= cmd_read_d;
      cmd_wdata_q <= cmd_wdata_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      m_q         <= m_d;
      od_q        <= od_d;
      outdiv_q    <= outdiv_d;
      by1_q       <= by1_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign o_icb_cmd_valid = cmd_valid_q;
  assign o_icb_cmd_addr  = cmd_addr_q;
  assign o_icb_cmd_read  = cmd_read_q;
  assign o_icb_cmd_wdata = cmd_wdata_q;
  assign o_icb_rsp_ready = 1'b1;
  assign dbg_state_o     = state_q;

endmodule
